bullet_fire_ctrl: RTL and testbench
===================================

Name: bullet_fire_ctrl

Overview:
- Shot manager for one tank; sits directly upstream of the per-bullet motion blocks.
- Turns the raw shoot key into one-cycle create pulses and allocates one of NUM_BULLETS bullet slots.
- Latches the tank pose at the instant of firing as the spawn point and heading.
- Tracks each slot's lifetime; retires slots on expiry or hit, and enforces a re-fire cooldown.

Parameters:
- NUM_BULLETS, 3, number of bullet slots per tank (1..8)
- LIFE_FRAMES, 240, frames a bullet stays alive (1..511)
- COOLDOWN_FRAMES, 15, frames after a shot during which fire edges are ignored (0 = no cooldown)

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame clock; one tick per frame
- fire_key  in  1  raw shoot key level, already synchronous to frame_clk
- tankX  in  10  tank centre X
- tankY  in  10  tank centre Y
- angle  in  6  tank heading index
- bullet_hit  in  NUM_BULLETS  per-slot retire request (tank hit or out of play), level-sampled
- create  out  NUM_BULLETS  one-hot, one-cycle spawn pulse to the bullet slots
- spawnX  out  10  X latched at the shot; held until the next shot
- spawnY  out  10  Y latched at the shot; held until the next shot
- spawnAngle  out  6  angle latched at the shot; held until the next shot
- bullet_alive  out  NUM_BULLETS  slot occupied
- shot_denied  out  1  one-cycle pulse: fire edge rejected because all slots were busy
- shots_free  out  4  count of free slots

Behaviour:
- Reset (async, any time, including mid-flight or mid-cooldown):
  - create=0, bullet_alive=0, shot_denied=0; spawnX/spawnY/spawnAngle=0.
  - All life counters=0, cooldown counter=0, FSM=READY.
  - Key-history register=1, so a key held through reset does not fire.
  - shots_free=NUM_BULLETS.
- Edge detect: key_prev registers fire_key every cycle; fire_edge = fire_key & ~key_prev. A held key produces exactly one edge.
- FSM states: READY, COOLDOWN.
- READY with fire_edge:
  - If a free slot exists (bullet_alive[k]=0): pick the lowest-index free slot k. On the next edge:
    - create[k]=1 for exactly one cycle, bullet_alive[k]=1, life[k]=LIFE_FRAMES.
    - spawnX/spawnY/spawnAngle take the tankX/tankY/angle sampled in the edge cycle.
    - If COOLDOWN_FRAMES>0: load cooldown=COOLDOWN_FRAMES and go to COOLDOWN; otherwise stay in READY.
  - If no slot is free: shot_denied=1 for one cycle, no create, state unchanged.
- COOLDOWN:
  - Decrement cooldown every cycle; fire edges are dropped, not queued, and do not assert shot_denied.
  - When cooldown reaches 0, go to READY. A shot at cycle N+1 is re-armed so that an edge at cycle N+1+COOLDOWN_FRAMES is accepted.
- Latency: fire_edge at cycle N -> create pulse and updated spawn outputs at cycle N+1. Spawn outputs are valid no later than the create pulse.
- Lifetime:
  - While bullet_alive[k], life[k] decrements once per cycle.
  - When life[k]=1 it decrements to 0 and bullet_alive[k] clears on that same edge, so alive is high exactly LIFE_FRAMES cycles.
- Hit:
  - bullet_hit[k]=1 while alive -> bullet_alive[k]=0 and life[k]=0 on the next edge.
  - bullet_hit on a dead slot is ignored.
- Simultaneous events:
  - A slot retired (expiry or hit) on cycle N is not selectable by a fire_edge in cycle N; free-slot selection uses the registered bullet_alive. It becomes available from cycle N+1.
  - Hits on several slots in the same cycle all retire together.
- Width rules: life counter is 9 bits and cooldown counter is 8 bits, both unsigned; neither ever wraps below 0. shots_free = NUM_BULLETS minus popcount(bullet_alive), combinational from registered state.
- create is never asserted on an alive slot, and at most one create bit is set per cycle.

Test Plan:
- Reset, then fire_key rising at cycle 10 with tankX=320, tankY=240, angle=5 -> cycle 11: create=3'b001, spawnX=320, spawnY=240, spawnAngle=5, bullet_alive=3'b001, shots_free=2.
- Hold fire_key high for 50 cycles -> exactly one create pulse; after the first shot, edges at cycles +5 and +10 (inside cooldown) produce no create and no shot_denied.
- Three edges spaced 20 cycles apart, then a 4th edge 20 cycles later -> create 001, 010, 100, then shot_denied=1 for one cycle; bullet_alive=3'b111, shots_free=0.
- Single shot with no hits -> bullet_alive[0] high for exactly 240 cycles and clears at cycle 251; the next edge reuses slot 0.
- Slots 0 and 1 alive; assert bullet_hit=3'b001 together with a fire edge in the same cycle -> that edge takes slot 2 (create=3'b100); slot 0 reads free one cycle later.
- Assert Reset asynchronously mid-cooldown with two slots alive -> all outputs zero immediately, shots_free=3; a key held through reset release does not fire until released and pressed again.

Source files
------------

// File: rtl/bullet_fire_ctrl.sv
// Shot manager for one tank: edge-detects the shoot key, allocates bullet slots,
// latches the spawn pose, and retires slots on expiry or hit behind a re-fire cooldown.
module bullet_fire_ctrl #(
    parameter int unsigned NUM_BULLETS     = 3,
    parameter int unsigned LIFE_FRAMES     = 240,
    parameter int unsigned COOLDOWN_FRAMES = 15
) (
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   fire_key,
    input  logic [9:0]             tankX,
    input  logic [9:0]             tankY,
    input  logic [5:0]             angle,
    input  logic [NUM_BULLETS-1:0] bullet_hit,
    output logic [NUM_BULLETS-1:0] create,
    output logic [9:0]             spawnX,
    output logic [9:0]             spawnY,
    output logic [5:0]             spawnAngle,
    output logic [NUM_BULLETS-1:0] bullet_alive,
    output logic                   shot_denied,
    output logic [3:0]             shots_free
);

    typedef enum logic {READY, COOLDOWN} state_t;

    state_t                 state;
    logic                   key_prev;
    logic                   fire_edge;
    logic [7:0]             cooldown;
    logic [8:0]             life [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] free_pick;
    logic                   accept;
    logic                   deny;
    logic [3:0]             alive_cnt;

    assign fire_edge = fire_key & ~key_prev;
    // Adding one to the alive mask carries into its lowest zero bit, isolating the lowest free slot.
    assign free_pick = ~bullet_alive & (bullet_alive + NUM_BULLETS'(1));
    assign accept    = (state == READY) && fire_edge && (free_pick != '0);
    assign deny      = (state == READY) && fire_edge && (free_pick == '0);

    always_comb begin
        alive_cnt = '0;
        for (int unsigned k = 0; k < NUM_BULLETS; k++) begin
            alive_cnt = alive_cnt + 4'(bullet_alive[k]);
        end
        shots_free = 4'(NUM_BULLETS) - alive_cnt;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state        <= READY;
            key_prev     <= 1'b1;
            cooldown     <= '0;
            create       <= '0;
            shot_denied  <= 1'b0;
            bullet_alive <= '0;
            spawnX       <= '0;
            spawnY       <= '0;
            spawnAngle   <= '0;
            for (int unsigned k = 0; k < NUM_BULLETS; k++) begin
                life[k] <= '0;
            end
        end else begin
            key_prev    <= fire_key;
            create      <= accept ? free_pick : '0;
            shot_denied <= deny;

            if (accept) begin
                spawnX     <= tankX;
                spawnY     <= tankY;
                spawnAngle <= angle;
            end

            for (int unsigned k = 0; k < NUM_BULLETS; k++) begin
                if (accept && free_pick[k]) begin
                    bullet_alive[k] <= 1'b1;
                    life[k]         <= 9'(LIFE_FRAMES);
                end else if (bullet_alive[k]) begin
                    if (bullet_hit[k] || life[k] <= 9'd1) begin
                        bullet_alive[k] <= 1'b0;
                        life[k]         <= '0;
                    end else begin
                        life[k] <= life[k] - 9'd1;
                    end
                end
            end

            case (state)
                READY: begin
                    if (accept && COOLDOWN_FRAMES > 0) begin
                        cooldown <= 8'(COOLDOWN_FRAMES);
                        state    <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // Leaving on the count of 1 re-arms exactly COOLDOWN_FRAMES cycles after the create pulse.
                    if (cooldown <= 8'd1) begin
                        cooldown <= '0;
                        state    <= READY;
                    end else begin
                        cooldown <= cooldown - 8'd1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Bench for bullet_fire_ctrl: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key/hit/reset traffic.
module tb_bullet_fire_ctrl;

    localparam int N = 3;
    localparam int L = 240;
    localparam int C = 15;

    logic         Reset;
    logic         frame_clk;
    logic         fire_key;
    logic [9:0]   tankX;
    logic [9:0]   tankY;
    logic [5:0]   angle;
    logic [N-1:0] bullet_hit;
    logic [N-1:0] create;
    logic [9:0]   spawnX;
    logic [9:0]   spawnY;
    logic [5:0]   spawnAngle;
    logic [N-1:0] bullet_alive;
    logic         shot_denied;
    logic [3:0]   shots_free;

    int errors = 0;
    int checks = 0;

    bullet_fire_ctrl #(
        .NUM_BULLETS(N),
        .LIFE_FRAMES(L),
        .COOLDOWN_FRAMES(C)
    ) dut (
        .Reset(Reset),
        .frame_clk(frame_clk),
        .fire_key(fire_key),
        .tankX(tankX),
        .tankY(tankY),
        .angle(angle),
        .bullet_hit(bullet_hit),
        .create(create),
        .spawnX(spawnX),
        .spawnY(spawnY),
        .spawnAngle(spawnAngle),
        .bullet_alive(bullet_alive),
        .shot_denied(shot_denied),
        .shots_free(shots_free)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each slot is described by the cycle at which it stops being alive,
    // and the cooldown by the first cycle in which a fire edge is honoured again.
    int           cyc = 0;
    int           dies_at [N];
    int           armed_at = 0;
    logic         m_prev = 1'b1;
    logic [N-1:0] m_create = '0;
    logic         m_denied = 1'b0;
    logic [9:0]   m_x = '0;
    logic [9:0]   m_y = '0;
    logic [5:0]   m_a = '0;
    int           t;
    bit           fe;
    bit           placed;

    initial for (int k = 0; k < N; k++) dies_at[k] = 0;

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < N; k++) dies_at[k] = 0;
            armed_at = 0;
            m_prev   = 1'b1;
            m_create = '0;
            m_denied = 1'b0;
            m_x = '0;
            m_y = '0;
            m_a = '0;
        end else begin
            t  = cyc;
            fe = fire_key && !m_prev;
            m_prev   = fire_key;
            m_create = '0;
            m_denied = 1'b0;
            placed   = 1'b0;
            // Free-slot choice looks at occupancy during cycle t, before this cycle's retirements land.
            if (fe && t >= armed_at) begin
                for (int k = 0; k < N; k++) begin
                    if (!placed && !(t < dies_at[k])) begin
                        placed      = 1'b1;
                        m_create[k] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (t < dies_at[k] && bullet_hit[k]) dies_at[k] = t + 1;
            end
            if (fe && t >= armed_at) begin
                if (placed) begin
                    for (int k = 0; k < N; k++) if (m_create[k]) dies_at[k] = t + 1 + L;
                    armed_at = t + 1 + C;
                    m_x = tankX;
                    m_y = tankY;
                    m_a = angle;
                end else begin
                    m_denied = 1'b1;
                end
            end
            cyc = t + 1;
        end
    end

    function automatic logic [N-1:0] m_alive();
        logic [N-1:0] a;
        for (int k = 0; k < N; k++) a[k] = (cyc < dies_at[k]);
        return a;
    endfunction

    function automatic int m_free();
        logic [N-1:0] a;
        int f;
        a = m_alive();
        f = N;
        for (int k = 0; k < N; k++) if (a[k]) f--;
        return f;
    endfunction

    always @(negedge frame_clk) begin
        check("create", 16'(create), 16'(m_create));
        check("shot_denied", 16'(shot_denied), 16'(m_denied));
        check("bullet_alive", 16'(bullet_alive), 16'(m_alive()));
        check("shots_free", 16'(shots_free), 16'(m_free()));
        check("spawnX", 16'(spawnX), 16'(m_x));
        check("spawnY", 16'(spawnY), 16'(m_y));
        check("spawnAngle", 16'(spawnAngle), 16'(m_a));
    end

    task automatic step();
        @(posedge frame_clk);
        #2;
    endtask

    task automatic press();
        fire_key = 1'b1;
        step();
        fire_key = 1'b0;
    endtask

    task automatic do_reset();
        fire_key   = 1'b0;
        bullet_hit = '0;
        Reset      = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    int n_create;
    int n_denied;
    int alive_len;

    initial begin
        Reset      = 1'b1;
        fire_key   = 1'b0;
        tankX      = '0;
        tankY      = '0;
        angle      = '0;
        bullet_hit = '0;
        step();
        step();
        check("rst_create", 16'(create), 16'h0);
        check("rst_alive", 16'(bullet_alive), 16'h0);
        check("rst_free", 16'(shots_free), 16'd3);
        check("rst_spawnX", 16'(spawnX), 16'h0);
        Reset = 1'b0;

        // First shot latches the pose.
        repeat (8) step();
        tankX = 10'd320;
        tankY = 10'd240;
        angle = 6'd5;
        press();
        check("s1_create", 16'(create), 16'b001);
        check("s1_spawnX", 16'(spawnX), 16'd320);
        check("s1_spawnY", 16'(spawnY), 16'd240);
        check("s1_angle", 16'(spawnAngle), 16'd5);
        check("s1_alive", 16'(bullet_alive), 16'b001);
        check("s1_free", 16'(shots_free), 16'd2);
        check("model_s1_create", 16'(m_create), 16'b001);
        check("model_s1_free", 16'(m_free()), 16'd2);

        // Held key fires once; edges inside cooldown are dropped silently.
        do_reset();
        fire_key = 1'b1;
        n_create = 0;
        repeat (50) begin
            step();
            if (create != '0) n_create++;
        end
        check("hold_one_create", 16'(n_create), 16'd1);
        fire_key = 1'b0;
        step();
        press();
        check("cd_first", 16'(create), 16'b010);
        repeat (5) step();
        press();
        check("cd_plus5_create", 16'(create), 16'h0);
        check("cd_plus5_denied", 16'(shot_denied), 16'h0);
        repeat (4) step();
        press();
        check("cd_plus10_create", 16'(create), 16'h0);
        check("cd_plus10_denied", 16'(shot_denied), 16'h0);
        repeat (4) step();
        press();
        check("cd_rearm", 16'(create), 16'b100);

        // Fill all slots, then a denied shot.
        do_reset();
        press();
        check("fill0", 16'(create), 16'b001);
        repeat (19) step();
        press();
        check("fill1", 16'(create), 16'b010);
        repeat (19) step();
        press();
        check("fill2", 16'(create), 16'b100);
        repeat (19) step();
        press();
        check("full_create", 16'(create), 16'h0);
        check("full_denied", 16'(shot_denied), 16'h1);
        check("full_alive", 16'(bullet_alive), 16'b111);
        check("full_free", 16'(shots_free), 16'd0);
        step();
        check("denied_one_cycle", 16'(shot_denied), 16'h0);

        // Lifetime of exactly L frames, then slot reuse.
        do_reset();
        press();
        alive_len = 0;
        while (bullet_alive[0] && alive_len < 300) begin
            alive_len++;
            step();
        end
        check("life_len", 16'(alive_len), 16'(L));
        press();
        check("life_reuse", 16'(create), 16'b001);

        // Hit and fire in the same cycle: the retiring slot is not yet selectable.
        do_reset();
        press();
        repeat (20) step();
        press();
        repeat (20) step();
        bullet_hit = 3'b001;
        press();
        bullet_hit = '0;
        check("hitfire_create", 16'(create), 16'b100);
        check("hitfire_alive", 16'(bullet_alive), 16'b110);
        check("hitfire_free", 16'(shots_free), 16'd1);

        // Asynchronous reset mid-cooldown with a key held through release.
        do_reset();
        press();
        repeat (20) step();
        press();
        repeat (3) step();
        fire_key = 1'b1;
        #1 Reset = 1'b1;
        #1;
        check("arst_create", 16'(create), 16'h0);
        check("arst_alive", 16'(bullet_alive), 16'h0);
        check("arst_denied", 16'(shot_denied), 16'h0);
        check("arst_spawnX", 16'(spawnX), 16'h0);
        check("arst_free", 16'(shots_free), 16'd3);
        step();
        Reset = 1'b0;
        n_create = 0;
        repeat (5) begin
            step();
            if (create != '0) n_create++;
        end
        check("held_through_reset", 16'(n_create), 16'd0);
        fire_key = 1'b0;
        step();
        press();
        check("after_release", 16'(create), 16'b001);

        // Randomized traffic, checked by the model every cycle.
        n_denied = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fire_key = ~fire_key;
            for (int k = 0; k < N; k++) bullet_hit[k] = ($urandom_range(0, 63) == 0);
            tankX = 10'($urandom);
            tankY = 10'($urandom);
            angle = 6'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                #3 Reset = 1'b1;
                step();
                Reset = 1'b0;
            end else begin
                step();
            end
            if (shot_denied) n_denied++;
        end
        bullet_hit = '0;
        fire_key   = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
